// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage.
// Entries carry the word-indexed PC alongside the fetched instruction.
package fetch_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Advance a word-indexed PC by one slot when a read is issued.
    function automatic logic [31:0] pc_advance(
        input logic [31:0] base,
        input logic        step
    );
        return base + {31'd0, step};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small skid FIFO between the instruction memory and the decoder.
// A clear wins over a simultaneous push or pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_pop;

    assign do_pop = pop && (count != '0);
    assign head   = mem[rd_ptr];

    // Pointer, occupancy and storage update; clear empties the buffer.
    always_ff @(posedge CLK) begin
        if (RSTN) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    no_push_when_full_a: assert property (
        @(posedge CLK) disable iff (RSTN)
        (push && !clear) |-> ((count < CW'(DEPTH)) || do_pop)
    );

endmodule

// File: rtl/fetcher.sv
// Instruction-fetch stage: PC generation, redirect handling and
// epoch-tagged capture of synchronous instruction-memory reads.
module fetcher
    import fetch_pkg::*;
#(
    parameter int          IMEM_ADDR_W = 10,
    parameter logic [31:0] RESET_PC    = 32'd0,
    parameter int          FIFO_DEPTH  = 2
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic                   FETCH_ENABLED,
    input  logic                   JUMP_VALID,
    input  logic [31:0]            JUMP_DEST,
    output logic                   IMEM_EN,
    output logic [IMEM_ADDR_W-1:0] IMEM_ADDR,
    input  logic [31:0]            IMEM_DATA,
    output logic                   INSTR_VALID,
    input  logic                   INSTR_READY,
    output logic [31:0]            INSTR,
    output logic [31:0]            INSTR_PC
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = CW + 1;

    fetch_state_t  state;
    logic [31:0]   pc;
    logic          epoch;
    logic          inflight;
    logic          inflight_epoch;
    logic [31:0]   inflight_pc;

    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  push_data;
    logic          push;
    logic          pop;
    logic          issue;
    logic          has_space;
    logic [OW-1:0] occupancy;
    logic [31:0]   issue_pc;

    assign INSTR_VALID = (count != '0);
    assign pop         = INSTR_VALID && INSTR_READY;

    // Slots already spoken for once this cycle's pop and arrival settle.
    assign occupancy = {1'b0, count}
                     + OW'(inflight)
                     - OW'(pop);
    assign has_space = occupancy < OW'(FIFO_DEPTH);

    // A redirect re-targets the read in the same cycle; the flush
    // guarantees room, so the space check is skipped.
    assign issue_pc = JUMP_VALID ? JUMP_DEST : pc;
    assign issue    = !RSTN
                   && (state == RUN)
                   && FETCH_ENABLED
                   && (JUMP_VALID || has_space);

    assign IMEM_EN   = issue;
    assign IMEM_ADDR = issue_pc[IMEM_ADDR_W-1:0];

    // Only responses from the current epoch belong on the right path.
    assign push            = inflight && (inflight_epoch == epoch);
    assign push_data.pc    = inflight_pc;
    assign push_data.instr = IMEM_DATA;

    assign INSTR    = INSTR_VALID ? head.instr : 32'd0;
    assign INSTR_PC = INSTR_VALID ? head.pc    : 32'd0;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .clear     (JUMP_VALID),
        .count     (count),
        .head      (head)
    );

    // Boot sequencing, PC/epoch tracking and in-flight read tagging.
    always_ff @(posedge CLK) begin
        if (RSTN) begin
            state          <= BOOT;
            pc             <= RESET_PC;
            epoch          <= 1'b0;
            inflight       <= 1'b0;
            inflight_epoch <= 1'b0;
            inflight_pc    <= 32'd0;
        end else begin
            unique case (state)
                BOOT: state <= RUN;
                RUN:  state <= RUN;
            endcase
            if (JUMP_VALID) begin
                epoch <= ~epoch;
            end
            pc       <= pc_advance(issue_pc, issue);
            inflight <= issue;
            if (issue) begin
                inflight_pc    <= issue_pc;
                inflight_epoch <= JUMP_VALID ? ~epoch : epoch;
            end
        end
    end

endmodule

// File: tb/tb_fetcher.sv
// Self-checking bench for the fetch stage: directed scenarios with
// literal expectations, then randomized traffic against a queue model.
module tb_fetcher;

    localparam int AW = 10;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b1;
    logic          FETCH_ENABLED = 1'b0;
    logic          JUMP_VALID = 1'b0;
    logic [31:0]   JUMP_DEST = 32'd0;
    logic          IMEM_EN;
    logic [AW-1:0] IMEM_ADDR;
    logic [31:0]   IMEM_DATA = 32'd0;
    logic          INSTR_VALID;
    logic          INSTR_READY = 1'b0;
    logic [31:0]   INSTR;
    logic [31:0]   INSTR_PC;

    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    fetcher #(
        .IMEM_ADDR_W (AW),
        .RESET_PC    (32'd0),
        .FIFO_DEPTH  (2)
    ) dut (
        .CLK           (CLK),
        .RSTN          (RSTN),
        .FETCH_ENABLED (FETCH_ENABLED),
        .JUMP_VALID    (JUMP_VALID),
        .JUMP_DEST     (JUMP_DEST),
        .IMEM_EN       (IMEM_EN),
        .IMEM_ADDR     (IMEM_ADDR),
        .IMEM_DATA     (IMEM_DATA),
        .INSTR_VALID   (INSTR_VALID),
        .INSTR_READY   (INSTR_READY),
        .INSTR         (INSTR),
        .INSTR_PC      (INSTR_PC)
    );

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return 32'h5A00_0000 ^ ({22'd0, a} * 32'h9E37_79B1);
    endfunction

    // Synchronous instruction memory: data one cycle after the request.
    always @(posedge CLK)
        IMEM_DATA <= IMEM_EN ? mem_word(IMEM_ADDR) : 32'hDEAD_BEEF;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: FIFO contents as a queue of (pc, instr).
    logic [31:0] q_pc[$];
    logic [31:0] q_ins[$];
    logic [31:0] acc[$];
    bit          m_known = 0;
    bit          m_run = 0;
    bit          m_inf = 0;
    logic [31:0] m_pc = 32'd0;
    logic [31:0] m_inf_pc = 32'd0;
    bit          e_pop;
    bit          e_issue;
    logic [31:0] e_target;

    always @(negedge CLK) begin
        bit          ev;
        logic [31:0] ei;
        logic [31:0] ep;
        ev = q_pc.size() > 0;
        ei = ev ? q_ins[0] : 32'd0;
        ep = ev ? q_pc[0] : 32'd0;
        e_pop = ev && INSTR_READY;
        e_target = JUMP_VALID ? JUMP_DEST : m_pc;
        e_issue = m_run && FETCH_ENABLED &&
                  (JUMP_VALID ||
                   (q_pc.size() + int'(m_inf) - int'(e_pop)) < 2);
        if (m_known && !RSTN) begin
            chk("imem_en", 32'(IMEM_EN), 32'(e_issue));
            chk("imem_addr", 32'(IMEM_ADDR), 32'(e_target[AW-1:0]));
            chk("instr_valid", 32'(INSTR_VALID), 32'(ev));
            chk("instr", INSTR, ei);
            chk("instr_pc", INSTR_PC, ep);
            if (INSTR_VALID && INSTR_READY)
                acc.push_back(INSTR_PC);
        end
    end

    always @(posedge CLK) begin
        if (RSTN) begin
            q_pc.delete();
            q_ins.delete();
            m_run = 0;
            m_inf = 0;
            m_pc = 32'd0;
            m_known = 1;
        end else if (m_known) begin
            if (JUMP_VALID) begin
                q_pc.delete();
                q_ins.delete();
            end else begin
                if (e_pop) begin
                    void'(q_pc.pop_front());
                    void'(q_ins.pop_front());
                end
                if (m_inf) begin
                    q_pc.push_back(m_inf_pc);
                    q_ins.push_back(mem_word(m_inf_pc[AW-1:0]));
                end
            end
            m_inf = e_issue;
            m_inf_pc = e_target;
            m_pc = e_target + (e_issue ? 32'd1 : 32'd0);
            m_run = 1;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] held;
        bit          found;
        int          n5;
        int          r;

        RSTN = 1'b1;
        FETCH_ENABLED = 1'b1;
        INSTR_READY = 1'b1;
        repeat (3) step();
        RSTN = 1'b0;

        // Reset then stream.
        smp();
        chk("boot_en", 32'(IMEM_EN), 0);
        chk("boot_valid", 32'(INSTR_VALID), 0);
        chk("boot_addr", 32'(IMEM_ADDR), 0);
        chk("boot_instr", INSTR, 0);
        step(); smp();
        chk("c1_en", 32'(IMEM_EN), 1);
        chk("c1_addr", 32'(IMEM_ADDR), 0);
        step(); smp();
        chk("c2_addr", 32'(IMEM_ADDR), 1);
        step(); smp();
        chk("c3_valid", 32'(INSTR_VALID), 1);
        chk("c3_pc", INSTR_PC, 0);
        chk("c3_instr", INSTR, mem_word(10'd0));
        step(); smp();
        chk("c4_pc", INSTR_PC, 1);

        // Backpressure.
        step();
        INSTR_READY = 1'b0;
        smp();
        held = INSTR_PC;
        chk("bp_head", held, 2);
        repeat (4) begin
            step(); smp();
            chk("bp_hold_pc", INSTR_PC, held);
        end
        chk("bp_en_low", 32'(IMEM_EN), 0);
        step();
        INSTR_READY = 1'b1;
        smp();
        chk("bp_rel0", INSTR_PC, 2);
        step(); smp();
        chk("bp_rel1", INSTR_PC, 3);
        step(); smp();
        chk("bp_rel2", INSTR_PC, 4);

        // Redirect while PC 5 is in flight.
        step();
        JUMP_VALID = 1'b1;
        JUMP_DEST = 32'd0;
        step();
        JUMP_VALID = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            smp();
            if (IMEM_EN && IMEM_ADDR == 10'd5) found = 1;
            else step();
        end
        chk("find_pc5", 32'(found), 1);
        step();
        JUMP_VALID = 1'b1;
        JUMP_DEST = 32'h40;
        acc.delete();
        smp();
        chk("rd_addr", 32'(IMEM_ADDR), 32'h40);
        step();
        JUMP_VALID = 1'b0;
        smp();
        chk("rd_gap", 32'(INSTR_VALID), 0);
        step(); smp();
        chk("rd_valid", 32'(INSTR_VALID), 1);
        chk("rd_pc0", INSTR_PC, 32'h40);
        step(); smp();
        chk("rd_pc1", INSTR_PC, 32'h41);
        repeat (3) step();
        n5 = 0;
        foreach (acc[i]) if (acc[i] == 32'd5) n5++;
        chk("pc5_dropped", 32'(n5), 0);

        // Redirect while fetch is disabled.
        FETCH_ENABLED = 1'b0;
        repeat (3) step();
        JUMP_VALID = 1'b1;
        JUMP_DEST = 32'h10;
        smp();
        chk("st_no_issue", 32'(IMEM_EN), 0);
        step();
        JUMP_VALID = 1'b0;
        smp();
        chk("st_no_issue2", 32'(IMEM_EN), 0);
        chk("st_empty", 32'(INSTR_VALID), 0);
        step();
        FETCH_ENABLED = 1'b1;
        smp();
        chk("st_en", 32'(IMEM_EN), 1);
        chk("st_addr", 32'(IMEM_ADDR), 32'h10);

        // Address wrap.
        step();
        JUMP_VALID = 1'b1;
        JUMP_DEST = 32'h3FF;
        smp();
        chk("wr_addr0", 32'(IMEM_ADDR), 32'h3FF);
        step();
        JUMP_VALID = 1'b0;
        smp();
        chk("wr_addr1", 32'(IMEM_ADDR), 32'h000);
        step(); smp();
        chk("wr_pc0", INSTR_PC, 32'h3FF);
        step(); smp();
        chk("wr_pc1", INSTR_PC, 32'h400);
        chk("wr_instr1", INSTR, mem_word(10'd0));

        // Reset mid-stream with a full FIFO.
        step();
        INSTR_READY = 1'b0;
        repeat (4) step();
        smp();
        chk("full_valid", 32'(INSTR_VALID), 1);
        chk("full_en", 32'(IMEM_EN), 0);
        step();
        RSTN = 1'b1;
        JUMP_VALID = 1'b1;
        JUMP_DEST = 32'h123;
        step();
        RSTN = 1'b0;
        JUMP_VALID = 1'b0;
        INSTR_READY = 1'b1;
        smp();
        chk("rst_en", 32'(IMEM_EN), 0);
        chk("rst_addr", 32'(IMEM_ADDR), 0);
        chk("rst_valid", 32'(INSTR_VALID), 0);
        chk("rst_instr", INSTR, 0);
        chk("rst_pc", INSTR_PC, 0);
        step(); smp();
        chk("rst_restart", 32'(IMEM_ADDR), 0);
        chk("rst_restart_en", 32'(IMEM_EN), 1);
        step(); step(); smp();
        chk("rst_first_pc", INSTR_PC, 0);

        // Randomized traffic, checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            step();
            FETCH_ENABLED = ($urandom % 10) != 0;
            INSTR_READY = ($urandom % 10) < 7;
            JUMP_VALID = ($urandom % 20) == 0;
            r = int'($urandom % 4);
            case (r)
                0: JUMP_DEST = $urandom;
                1: JUMP_DEST = 32'h3FE + ($urandom % 3);
                2: JUMP_DEST = 32'hFFFF_FFFE + ($urandom % 2);
                default: JUMP_DEST = $urandom % 64;
            endcase
            RSTN = ($urandom % 200) == 0;
        end
        step();
        RSTN = 1'b0;
        JUMP_VALID = 1'b0;
        repeat (5) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
